// File: rtl/mux4_1_rr_sel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_pkg
// Brief    : Shared types, sizes and helpers for the round-robin mux select.
// Revision : 1.0 - initial release
// ============================================================================
package mux_pkg;

    localparam int NUM_PORTS = 4;
    localparam int SEL_W     = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_PORTS-1:0] onehot4(input logic [SEL_W-1:0] sel);
        onehot4 = 4'b0001 << sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux4_1_rr_sel_if.sv
`default_nettype none
// ============================================================================
// Module   : mux4_1_rr_sel_if
// Brief    : Request/grant and downstream valid/ready bundle of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface mux4_1_rr_sel_if;
    import mux_pkg::*;

    logic [NUM_PORTS-1:0] req;
    logic                 out_ready;
    logic [SEL_W-1:0]     sel;
    logic [NUM_PORTS-1:0] gnt;
    logic                 out_valid;
    logic                 busy;

    modport master (
        input  req,
        input  out_ready,
        output sel,
        output gnt,
        output out_valid,
        output busy
    );

    modport slave (
        output req,
        output out_ready,
        input  sel,
        input  gnt,
        input  out_valid,
        input  busy
    );

endinterface
`default_nettype wire

// File: rtl/mux4_1_rr_sel_pick.sv
`default_nettype none
// ============================================================================
// Module   : mux4_1_rr_pick
// Brief    : First requester found scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
// Revision : 1.0 - initial release
// ============================================================================
module mux4_1_rr_pick
    import mux_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [SEL_W-1:0]     ptr,
    output logic                 any,
    output logic [SEL_W-1:0]     idx
);

    logic [SEL_W-1:0] w_cand;

    // Scan farthest offset first so the nearest hit to ptr overwrites the rest.
    always_comb begin
        any    = 1'b0;
        idx    = ptr;
        w_cand = ptr;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            w_cand = ptr + SEL_W'(i);
            if (req[w_cand]) begin
                any = 1'b1;
                idx = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux4_1_rr_sel.sv
`default_nettype none
// ============================================================================
// Module   : mux4_1_rr_sel
// Brief    : Round-robin burst-capped select sequencer driving a 4:1 mux sel.
// Revision : 1.0 - initial release
// ============================================================================
module mux4_1_rr_sel
    import mux_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    mux4_1_rr_sel_if.master    bus
);

    localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(MAX_BURST - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [SEL_W-1:0]     r_sel;
    logic [SEL_W-1:0]     w_sel_nxt;
    logic [SEL_W-1:0]     r_ptr;
    logic [SEL_W-1:0]     w_ptr_nxt;
    logic [NUM_PORTS-1:0] r_gnt;
    logic [NUM_PORTS-1:0] w_gnt_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;

    logic [SEL_W-1:0]     w_pick_ptr;
    logic [SEL_W-1:0]     w_pick_idx;
    logic                 w_any;
    logic                 w_granted;
    logic                 w_valid;
    logic                 w_xfer;
    logic                 w_release;

    assign w_granted = (r_state == GRANT);
    assign w_valid   = w_granted && bus.req[r_sel];
    assign w_xfer    = w_valid && bus.out_ready;
    assign w_release = w_granted && ((w_xfer && (r_cnt == c_last_beat)) || !bus.req[r_sel]);

    // On release the holder's successor leads the scan, so the holder comes last.
    assign w_pick_ptr = w_granted ? (r_sel + SEL_W'(1)) : r_ptr;

    mux4_1_rr_pick u_pick (
        .req (bus.req),
        .ptr (w_pick_ptr),
        .any (w_any),
        .idx (w_pick_idx)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = r_gnt;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = GRANT;
                    w_sel_nxt   = w_pick_idx;
                    w_gnt_nxt   = onehot4(w_pick_idx);
                    w_cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_ptr_nxt = w_pick_ptr;
                    if (w_any) begin
                        w_sel_nxt = w_pick_idx;
                        w_gnt_nxt = onehot4(w_pick_idx);
                        w_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = '0;
                    end
                end else if (w_xfer) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign bus.sel       = r_sel;
    assign bus.gnt       = r_gnt;
    assign bus.out_valid = w_valid;
    assign bus.busy      = w_granted;

endmodule
`default_nettype wire

// File: tb/tb_mux4_1_rr_sel.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_1_rr_sel
// Brief    : Directed vector bench for the round-robin mux select sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux4_1_rr_sel;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rdy;
        logic [1:0] sel;
        logic [3:0] gnt;
        logic       valid;
        logic       busy;
    } vec_t;

    localparam int c_nvec = 28;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tbl [c_nvec];

    always #5 clk = ~clk;

    mux4_1_rr_sel_if if_a ();
    mux4_1_rr_sel_if if_b ();

    mux4_1_rr_sel #(.MAX_BURST(4), .CNT_W(4)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (if_a.master)
    );

    mux4_1_rr_sel #(.MAX_BURST(1), .CNT_W(1)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (if_b.master)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        // {rst, req, out_ready, exp sel, exp gnt, exp out_valid, exp busy}
        tbl[0]  = '{1'b1, 4'b1111, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 4'b1111, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 4'b0011, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 4'b0011, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 4'b0011, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 4'b0011, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 4'b0011, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 4'b1001, 1'b1, 2'd1, 4'b0010, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 4'b0100, 1'b0, 2'd3, 4'b1000, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 4'b0101, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b1};
        for (int i = 10; i < 15; i++)
            tbl[i] = '{1'b0, 4'b0101, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b1};
        tbl[15] = '{1'b0, 4'b0101, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b1};
        tbl[16] = '{1'b0, 4'b0101, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b1};
        tbl[17] = '{1'b0, 4'b0101, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b1};
        tbl[18] = '{1'b0, 4'b0101, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1};
        tbl[19] = '{1'b0, 4'b0101, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1};
        tbl[20] = '{1'b1, 4'b0101, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1};
        tbl[21] = '{1'b0, 4'b0100, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0};
        tbl[22] = '{1'b0, 4'b0100, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b1};
        tbl[23] = '{1'b0, 4'b0000, 1'b1, 2'd2, 4'b0100, 1'b0, 1'b1};
        tbl[24] = '{1'b0, 4'b0000, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0};
        tbl[25] = '{1'b1, 4'b0000, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0};
        tbl[26] = '{1'b0, 4'b1001, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0};
        tbl[27] = '{1'b0, 4'b1001, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1};

        rst_a            = 1'b1;
        rst_b            = 1'b1;
        if_a.req         = 4'b0000;
        if_a.out_ready   = 1'b0;
        if_b.req         = 4'b1111;
        if_b.out_ready   = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < c_nvec; i++) begin
            @(negedge clk);
            rst_a          = tbl[i].rst;
            if_a.req       = tbl[i].req;
            if_a.out_ready = tbl[i].rdy;
            #1;
            chk($sformatf("v%0d sel", i),   8'(if_a.sel),       8'(tbl[i].sel));
            chk($sformatf("v%0d gnt", i),   8'(if_a.gnt),       8'(tbl[i].gnt));
            chk($sformatf("v%0d valid", i), 8'(if_a.out_valid), 8'(tbl[i].valid));
            chk($sformatf("v%0d busy", i),  8'(if_a.busy),      8'(tbl[i].busy));
        end

        // Single-beat bursts: every transfer rotates to the next port.
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        chk("rr idle gnt", 8'(if_b.gnt), 8'h00);
        for (int k = 0; k < 8; k++) begin
            logic [1:0] exp_sel;
            exp_sel = 2'(k % 4);
            @(negedge clk);
            #1;
            chk($sformatf("rr%0d sel", k),    8'(if_b.sel),           8'(exp_sel));
            chk($sformatf("rr%0d gnt", k),    8'(if_b.gnt),           8'(4'b0001 << exp_sel));
            chk($sformatf("rr%0d onehot", k), 8'($onehot(if_b.gnt)),  8'h01);
        end

        // Stall holds the select; release follows the first accepted beat.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if_b.out_ready = 1'b0;
            #1;
            chk($sformatf("rr stall%0d sel", k),   8'(if_b.sel),       8'h00);
            chk($sformatf("rr stall%0d valid", k), 8'(if_b.out_valid), 8'h01);
        end
        @(negedge clk);
        if_b.out_ready = 1'b1;
        #1;
        chk("rr resume sel", 8'(if_b.sel), 8'h00);
        @(negedge clk);
        #1;
        chk("rr next sel", 8'(if_b.sel), 8'h01);
        chk("rr next gnt", 8'(if_b.gnt), 8'h02);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
